// File: rtl/tl_fc_pkg.sv
// Shared definitions for the TL RX flow-control update path: type codes, FSM
// encoding, scale codes and the default INIT timeout.
package tl_fc_pkg;

    localparam int NUM_FC_TYPES         = 3;
    localparam int DEFAULT_INIT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        FC_P    = 2'b00,
        FC_NP   = 2'b01,
        FC_CPL  = 2'b10,
        FC_RSVD = 2'b11
    } fc_type_e;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_INIT     = 2'b01,
        ST_ACTIVE   = 2'b10
    } fc_state_e;

    typedef enum logic [1:0] {
        SCALE_NONE = 2'b00,
        SCALE_1X   = 2'b01,
        SCALE_4X   = 2'b10,
        SCALE_16X  = 2'b11
    } fc_scale_e;

endpackage

// File: rtl/tl_rx_fc_credit_bank.sv
// Three-entry (P/NP/CPL) register file holding InitFC credits/scales and the
// current credit limits, with a checker-side and a rd_type-side read mux.
module tl_rx_fc_credit_bank
    import tl_fc_pkg::*;
#(
    parameter int HDR_W  = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_init,
    input  logic              wr_limit,
    input  logic [1:0]        wr_type,
    input  logic [HDR_W-1:0]  wr_hdr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_hdr_scale,
    input  logic [1:0]        wr_data_scale,
    input  logic [1:0]        chk_type,
    output logic [HDR_W-1:0]  chk_hdr,
    output logic [DATA_W-1:0] chk_data,
    output logic [1:0]        chk_hdr_scale,
    output logic [1:0]        chk_data_scale,
    input  logic [1:0]        rd_type,
    output logic [HDR_W-1:0]  rd_hdr,
    output logic [DATA_W-1:0] rd_data
);

    logic [HDR_W-1:0]  init_hdr_vec   [NUM_FC_TYPES];
    logic [DATA_W-1:0] init_data_vec  [NUM_FC_TYPES];
    logic [1:0]        init_hscl_vec  [NUM_FC_TYPES];
    logic [1:0]        init_dscl_vec  [NUM_FC_TYPES];
    logic [HDR_W-1:0]  lim_hdr_vec    [NUM_FC_TYPES];
    logic [DATA_W-1:0] lim_data_vec   [NUM_FC_TYPES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FC_TYPES; gi++) begin : g_entry
            localparam logic [1:0] ENTRY = 2'(gi);
            logic [HDR_W-1:0]  init_hdr_reg;
            logic [DATA_W-1:0] init_data_reg;
            logic [1:0]        init_hscl_reg;
            logic [1:0]        init_dscl_reg;
            logic [HDR_W-1:0]  lim_hdr_reg;
            logic [DATA_W-1:0] lim_data_reg;
            logic              sel;

            assign sel = (wr_type == ENTRY);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    init_hdr_reg  <= '0;
                    init_data_reg <= '0;
                    init_hscl_reg <= '0;
                    init_dscl_reg <= '0;
                    lim_hdr_reg   <= '0;
                    lim_data_reg  <= '0;
                end else if (clr) begin
                    init_hdr_reg  <= '0;
                    init_data_reg <= '0;
                    init_hscl_reg <= '0;
                    init_dscl_reg <= '0;
                    lim_hdr_reg   <= '0;
                    lim_data_reg  <= '0;
                end else if (wr_init && sel) begin
                    init_hdr_reg  <= wr_hdr;
                    init_data_reg <= wr_data;
                    init_hscl_reg <= wr_hdr_scale;
                    init_dscl_reg <= wr_data_scale;
                    lim_hdr_reg   <= wr_hdr;
                    lim_data_reg  <= wr_data;
                end else if (wr_limit && sel) begin
                    lim_hdr_reg   <= wr_hdr;
                    lim_data_reg  <= wr_data;
                end
            end

            assign init_hdr_vec[gi]  = init_hdr_reg;
            assign init_data_vec[gi] = init_data_reg;
            assign init_hscl_vec[gi] = init_hscl_reg;
            assign init_dscl_vec[gi] = init_dscl_reg;
            assign lim_hdr_vec[gi]   = lim_hdr_reg;
            assign lim_data_vec[gi]  = lim_data_reg;
        end
    endgenerate

    // The reserved type code reads back as zero on both muxes.
    always_comb begin
        chk_hdr        = '0;
        chk_data       = '0;
        chk_hdr_scale  = '0;
        chk_data_scale = '0;
        rd_hdr         = '0;
        rd_data        = '0;
        if (chk_type != FC_RSVD) begin
            chk_hdr        = init_hdr_vec[chk_type];
            chk_data       = init_data_vec[chk_type];
            chk_hdr_scale  = init_hscl_vec[chk_type];
            chk_data_scale = init_dscl_vec[chk_type];
        end
        if (rd_type != FC_RSVD) begin
            rd_hdr  = lim_hdr_vec[rd_type];
            rd_data = lim_data_vec[rd_type];
        end
    end

endmodule

// File: rtl/tl_rx_fc_update_controller.sv
// Receive-side FC DLLP sequencer: captures InitFC values, tracks FC init state
// with a restart timeout, and commits or rejects UpdateFCs per checker verdict.
module tl_rx_fc_update_controller
    import tl_fc_pkg::*;
#(
    parameter int FC_DATA_CREDS_WIDTH  = 16,
    parameter int FC_HDR_CREDS_WIDTH   = 12,
    parameter int DLL_DATA_CREDS_WIDTH = 16,
    parameter int DLL_HDR_CREDS_WIDTH  = 12,
    parameter int INIT_TIMEOUT         = DEFAULT_INIT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dll_link_up,
    input  logic                           dll_valid,
    input  logic                           dll_init,
    input  logic [1:0]                     dll_fc_type,
    input  logic [DLL_HDR_CREDS_WIDTH-1:0] dll_hdr_creds,
    input  logic [DLL_DATA_CREDS_WIDTH-1:0] dll_data_creds,
    input  logic [1:0]                     dll_hdr_scale,
    input  logic [1:0]                     dll_data_scale,
    input  logic                           flow_control_error,
    output logic [FC_HDR_CREDS_WIDTH-1:0]  hdr_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0] data_creds_reg,
    output logic [1:0]                     hdr_scale_reg,
    output logic [1:0]                     data_scale_reg,
    output logic                           flow_control_en,
    output logic                           fc_init_done,
    input  logic [1:0]                     rd_type,
    output logic [FC_HDR_CREDS_WIDTH-1:0]  rd_hdr_limit,
    output logic [FC_DATA_CREDS_WIDTH-1:0] rd_data_limit,
    output logic                           update_valid,
    output logic                           fc_protocol_error,
    output logic                           init_timeout
);

    localparam int CNT_W = $clog2(INIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_TIMEOUT - 1);

    fc_state_e        state_reg;
    logic [2:0]       flags_reg;
    logic [2:0]       flags_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       type_oh;
    logic             type_ok;
    logic             init_hit;
    logic             init_complete;
    logic             timeout_now;
    logic             wr_init;
    logic             wr_limit;
    logic             bank_clr;

    assign type_ok       = (dll_fc_type != FC_RSVD);
    assign type_oh       = 3'b001 << dll_fc_type;
    assign init_hit      = (state_reg == ST_INIT) && dll_link_up && dll_valid && dll_init
                           && type_ok && |(type_oh & ~flags_reg);
    assign flags_next    = init_hit ? (flags_reg | type_oh) : flags_reg;
    assign init_complete = &flags_next;
    assign timeout_now   = (cnt_reg == CNT_LAST);

    assign flow_control_en = (state_reg == ST_ACTIVE) && dll_valid && !dll_init && type_ok;

    // A capture in the expiring cycle survives only if it completes init.
    assign wr_init  = init_hit && (init_complete || !timeout_now);
    assign wr_limit = flow_control_en && dll_link_up && !flow_control_error;
    assign bank_clr = !dll_link_up || (state_reg == ST_DISABLED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_DISABLED;
            flags_reg         <= '0;
            cnt_reg           <= '0;
            fc_init_done      <= 1'b0;
            update_valid      <= 1'b0;
            fc_protocol_error <= 1'b0;
            init_timeout      <= 1'b0;
        end else begin
            update_valid      <= 1'b0;
            fc_protocol_error <= 1'b0;
            init_timeout      <= 1'b0;
            if (!dll_link_up) begin
                state_reg    <= ST_DISABLED;
                flags_reg    <= '0;
                cnt_reg      <= '0;
                fc_init_done <= 1'b0;
            end else begin
                case (state_reg)
                    ST_DISABLED: begin
                        state_reg <= ST_INIT;
                        flags_reg <= '0;
                        cnt_reg   <= '0;
                    end
                    ST_INIT: begin
                        if (init_complete) begin
                            state_reg    <= ST_ACTIVE;
                            flags_reg    <= flags_next;
                            cnt_reg      <= '0;
                            fc_init_done <= 1'b1;
                        end else if (timeout_now) begin
                            init_timeout <= 1'b1;
                            flags_reg    <= '0;
                            cnt_reg      <= '0;
                        end else begin
                            flags_reg <= flags_next;
                            cnt_reg   <= cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        if (flow_control_en) begin
                            if (flow_control_error) fc_protocol_error <= 1'b1;
                            else                    update_valid      <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_DISABLED;
                endcase
            end
        end
    end

    tl_rx_fc_credit_bank #(
        .HDR_W  (FC_HDR_CREDS_WIDTH),
        .DATA_W (FC_DATA_CREDS_WIDTH)
    ) u_bank (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (bank_clr),
        .wr_init        (wr_init),
        .wr_limit       (wr_limit),
        .wr_type        (dll_fc_type),
        .wr_hdr         (FC_HDR_CREDS_WIDTH'(dll_hdr_creds)),
        .wr_data        (FC_DATA_CREDS_WIDTH'(dll_data_creds)),
        .wr_hdr_scale   (dll_hdr_scale),
        .wr_data_scale  (dll_data_scale),
        .chk_type       (dll_fc_type),
        .chk_hdr        (hdr_creds_reg),
        .chk_data       (data_creds_reg),
        .chk_hdr_scale  (hdr_scale_reg),
        .chk_data_scale (data_scale_reg),
        .rd_type        (rd_type),
        .rd_hdr         (rd_hdr_limit),
        .rd_data        (rd_data_limit)
    );

endmodule

// File: doc/tl_rx_fc_update_controller.md
# tl_rx_fc_update_controller

Sequences receive-side flow-control DLLP processing in the TL RX write handler. It captures InitFC credits and scales per FC type (P, NP, CPL) from the DLL and tracks FC initialisation state. It presents the stored per-type values to the flow-control error checker, `TL_RX_error_check_flow_control`, which is instantiated alongside this block. It commits or rejects each UpdateFC based on the checker's same-cycle verdict.

## Interface
Parameters:
- FC_DATA_CREDS_WIDTH, 16, width of stored data credits
- FC_HDR_CREDS_WIDTH, 12, width of stored header credits
- DLL_DATA_CREDS_WIDTH, 16, width of DLL data credit field
- DLL_HDR_CREDS_WIDTH, 12, width of DLL header credit field
- INIT_TIMEOUT, 4096, cycles allowed in INIT before restart

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dll_link_up  in  1  DL_Up from DLL
- dll_valid  in  1  FC DLLP present this cycle
- dll_init  in  1  1 = InitFC, 0 = UpdateFC
- dll_fc_type  in  2  00 P, 01 NP, 10 CPL, 11 reserved
- dll_hdr_creds / dll_data_creds  in  DLL_HDR/DATA_CREDS_WIDTH  advertised credits
- dll_hdr_scale / dll_data_scale  in  2  advertised scales
- flow_control_error  in  1  checker verdict, combinational, same cycle
- hdr_creds_reg / data_creds_reg  out  FC_HDR/DATA_CREDS_WIDTH  stored InitFC credits of dll_fc_type (combinational mux)
- hdr_scale_reg / data_scale_reg  out  2  stored InitFC scales of dll_fc_type
- flow_control_en  out  1  combinational: dll_valid checkable this cycle
- fc_init_done  out  1  registered, all three types initialised
- rd_type  in  2  credit-limit read select
- rd_hdr_limit / rd_data_limit  out  FC_HDR/DATA_CREDS_WIDTH  current limit for rd_type
- update_valid  out  1  one-cycle pulse, limit updated
- fc_protocol_error  out  1  one-cycle pulse, UpdateFC rejected
- init_timeout  out  1  one-cycle pulse, INIT restarted

## Operation
FSM states: DISABLED, INIT, ACTIVE.
- DISABLED:
  - All stored values, init flags and limits are cleared.
  - dll_link_up=1 moves the FSM to INIT.
- INIT:
  - An InitFC for a type whose init flag is 0 captures creds and scales into both the init registers and the limit registers, then sets the flag.
  - A repeated InitFC for an already-flagged type is ignored.
  - UpdateFC is ignored.
  - When all three flags are set, the FSM moves to ACTIVE and fc_init_done becomes 1.
  - If INIT_TIMEOUT cycles elapse without completing, init_timeout pulses, all flags are cleared, the counter restarts, and the FSM stays in INIT.
- ACTIVE:
  - flow_control_en = dll_valid & ~dll_init & (type != 11).
  - If flow_control_error=0, the UpdateFC overwrites the limit registers of that type and update_valid pulses.
  - If flow_control_error=1, the limits are unchanged and fc_protocol_error pulses.
  - InitFC is ignored.
- Reserved type 11 is ignored in every state and produces no pulse.
- dll_link_up=0 in any state moves the FSM to DISABLED.
- Credit widths: DLL fields are zero-extended or truncated to FC widths on capture.

## Timing
- Reset values: all outputs 0, state DISABLED, counter 0.
- Capture and update happen on the edge that samples dll_valid. Stored values are visible on the mux and read outputs the following cycle.
- update_valid and fc_protocol_error assert in the cycle after the DLLP and last exactly one cycle.
- fc_init_done rises in the cycle after the final InitFC capture.
- The timeout counter increments each cycle in INIT. The pulse fires when the count reaches INIT_TIMEOUT-1.
- A link-down edge coinciding with dll_valid: link-down wins and nothing is captured or pulsed.
- An InitFC completing init in the same cycle the timeout expires: completion wins and there is no timeout pulse.
- Asynchronous reset mid-operation clears everything immediately. Back-to-back DLLPs every cycle are supported.

## Structure
- Shared package tl_fc_pkg holds:
  - FC type codes FC_P, FC_NP, FC_CPL
  - state encoding
  - scale codes
  - default INIT_TIMEOUT
- Sub-module tl_rx_fc_credit_bank holds the three-entry init/limit register file with a write port and two read muxes (checker side and rd_type side). The FSM, counter and pulses stay in the top module.

## Test plan
- Link up, InitFC P(hdr 32, data 256, scale 00), NP(8, 0), CPL(0, 0) -> fc_init_done=1 one cycle after the CPL capture; rd_type=01 gives hdr 8.
- ACTIVE, UpdateFC P hdr 40 data 300, checker error 0 -> update_valid pulse; rd_hdr_limit=40, rd_data_limit=300.
- ACTIVE, UpdateFC CPL hdr 5 (stored 0, checker flags error) -> fc_protocol_error pulse; CPL limit stays 0.
- INIT with only P and NP received, INIT_TIMEOUT=16 -> init_timeout pulse at cycle 16; flags cleared; P must be re-captured.
- dll_link_up drop in the same cycle as a valid UpdateFC -> no pulse, state DISABLED, all limits 0.
- rst_n asserted mid-ACTIVE -> all outputs 0 asynchronously; after release with link up, the block re-enters INIT.
